// File: rtl/mem_wb_staged_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// Latency: none, this is wiring only.
// Backpressure: the master holds its request until the slave answers with mem_ack.
interface mem_wb_staged_if #(
    parameter int DATA_W = 64
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mem_wb_staged.sv
// MEM/WB stage: latches ALU-stage results, runs the data-memory handshake, registers the write-back bundle.
// Latency: EX->WB two edges; each memory wait cycle adds one edge, bounded at MAX_WAIT request cycles.
// Backpressure: stall freezes IF/RF/EX and the M register while a memory access is outstanding.
module mem_wb_staged #(
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ALU_in,
    input  logic [DATA_W-1:0] StoreData_in,
    input  logic [DATA_W-1:0] PCPlusFour_in,
    input  logic [4:0]        Aw_in,
    input  logic              MemToReg_in,
    input  logic              MemWrite_in,
    input  logic              RegWrite_in,
    input  logic              Rd_X30_in,
    output logic              stall,
    mem_wb_staged_if.master   dmem,
    output logic [4:0]        Aw_WB,
    output logic              RegWrite_WB,
    output logic [DATA_W-1:0] MemStage_WB,
    output logic [DATA_W-1:0] PCPlusFour_WB,
    output logic              Rd_X30_WB,
    output logic [DATA_W-1:0] WB_fwd,
    output logic              mem_err
);
    localparam int              CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               timeout_now;
    logic               memop;
    logic               done;

    // M register contents
    logic               m_valid;
    logic [DATA_W-1:0]  m_ALU;
    logic [DATA_W-1:0]  m_StoreData;
    logic [DATA_W-1:0]  m_PCPlusFour;
    logic [4:0]         m_Aw;
    logic               m_MemToReg;
    logic               m_MemWrite;
    logic               m_RegWrite;
    logic               m_Rd_X30;

    // M register: capture the EX-stage instruction unless the access in M is still pending
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid      <= 1'b0;
            m_ALU        <= '0;
            m_StoreData  <= '0;
            m_PCPlusFour <= '0;
            m_Aw         <= '0;
            m_MemToReg   <= 1'b0;
            m_MemWrite   <= 1'b0;
            m_RegWrite   <= 1'b0;
            m_Rd_X30     <= 1'b0;
        end else if (!stall) begin
            m_valid      <= ex_valid;
            m_ALU        <= ALU_in;
            m_StoreData  <= StoreData_in;
            m_PCPlusFour <= PCPlusFour_in;
            m_Aw         <= Aw_in;
            m_MemToReg   <= MemToReg_in;
            m_MemWrite   <= MemWrite_in;
            m_RegWrite   <= RegWrite_in;
            m_Rd_X30     <= Rd_X30_in;
        end
    end

    // A store wins when both control bits are set, so the request is a write.
    // Both FSM states request, so any memop in M is always on the bus.
    assign memop          = m_valid & (m_MemToReg | m_MemWrite);
    assign dmem.mem_req   = memop & ((state == ST_IDLE) | (state == ST_WAIT));
    assign dmem.mem_we    = m_MemWrite;
    assign dmem.mem_addr  = m_ALU;
    assign dmem.mem_wdata = m_StoreData;

    assign done  = ~memop | dmem.mem_ack | timeout_now;
    assign stall = memop & ~done;

    // Handshake FSM and sticky error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            mem_err <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (timeout_now) begin
                mem_err <= 1'b1;
            end
        end
    end

    // Next state: count request cycles without ack and give up on the last one
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_now = 1'b0;
        if (state == ST_IDLE) begin
            if (memop && !dmem.mem_ack) begin
                state_nxt = ST_WAIT;
                cnt_nxt   = CNT_W'(1);
            end
        end else begin
            if (dmem.mem_ack) begin
                state_nxt = ST_IDLE;
            end else if (cnt == CNT_LAST) begin
                state_nxt   = ST_IDLE;
                timeout_now = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // WB register: one write per completed instruction, write enable pulses for a single edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Aw_WB         <= '0;
            RegWrite_WB   <= 1'b0;
            MemStage_WB   <= '0;
            PCPlusFour_WB <= '0;
            Rd_X30_WB     <= 1'b0;
        end else if (m_valid && done) begin
            Aw_WB         <= m_Aw;
            Rd_X30_WB     <= m_Rd_X30;
            PCPlusFour_WB <= m_PCPlusFour;
            // a timed-out load writes nothing, and its data field is zeroed
            if (m_MemToReg && !m_MemWrite) begin
                MemStage_WB <= timeout_now ? '0 : dmem.mem_rdata;
            end else begin
                MemStage_WB <= m_ALU;
            end
            RegWrite_WB   <= m_RegWrite & ~(timeout_now & m_MemToReg);
        end else begin
            RegWrite_WB   <= 1'b0;
        end
    end

    assign WB_fwd = Rd_X30_WB ? PCPlusFour_WB : MemStage_WB;

endmodule

// File: tb/tb_mem_wb_staged.sv
// Directed bench for mem_wb_staged: per-cycle vector table plus timeout and reset sequences.
// Latency: inputs driven on the falling edge, combinational outputs sampled 1 ns later, WB 1 ns after the rise.
// Backpressure: the bench keeps presenting the held EX instruction while stall is high.
module tb_mem_wb_staged;
    localparam int DATA_W   = 64;
    localparam int MAX_WAIT = 16;
    localparam int NV       = 13;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              ex_valid;
    logic [DATA_W-1:0] ALU_in, StoreData_in, PCPlusFour_in;
    logic [4:0]        Aw_in;
    logic              MemToReg_in, MemWrite_in, RegWrite_in, Rd_X30_in;
    logic              stall;
    logic [4:0]        Aw_WB;
    logic              RegWrite_WB;
    logic [DATA_W-1:0] MemStage_WB, PCPlusFour_WB, WB_fwd;
    logic              Rd_X30_WB;
    logic              mem_err;

    int errors = 0;
    int checks = 0;

    mem_wb_staged_if #(.DATA_W(DATA_W)) dmem ();

    mem_wb_staged #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ex_valid      (ex_valid),
        .ALU_in        (ALU_in),
        .StoreData_in  (StoreData_in),
        .PCPlusFour_in (PCPlusFour_in),
        .Aw_in         (Aw_in),
        .MemToReg_in   (MemToReg_in),
        .MemWrite_in   (MemWrite_in),
        .RegWrite_in   (RegWrite_in),
        .Rd_X30_in     (Rd_X30_in),
        .stall         (stall),
        .dmem          (dmem),
        .Aw_WB         (Aw_WB),
        .RegWrite_WB   (RegWrite_WB),
        .MemStage_WB   (MemStage_WB),
        .PCPlusFour_WB (PCPlusFour_WB),
        .Rd_X30_WB     (Rd_X30_WB),
        .WB_fwd        (WB_fwd),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    // ctl = {MemToReg, MemWrite, RegWrite, Rd_X30}; e_srw = {stall, mem_req, mem_we}
    typedef struct {
        logic        v;
        logic [63:0] alu, sd, pc4;
        logic [4:0]  aw;
        logic [3:0]  ctl;
        logic        ack;
        logic [63:0] rdata;
        logic [2:0]  e_srw;
        logic [63:0] e_addr, e_wdata;
        logic [4:0]  e_aw;
        logic        e_rw;
        logic [63:0] e_ms, e_fwd;
    } vec_t;

    vec_t tv [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] alu, input logic [63:0] sd,
                         input logic [63:0] pc4, input logic [4:0] aw, input logic [3:0] ctl);
        ex_valid      = v;
        ALU_in        = alu;
        StoreData_in  = sd;
        PCPlusFour_in = pc4;
        Aw_in         = aw;
        MemToReg_in   = ctl[3];
        MemWrite_in   = ctl[2];
        RegWrite_in   = ctl[1];
        Rd_X30_in     = ctl[0];
    endtask

    task automatic bubble();
        drive(1'b0, 64'h0, 64'h0, 64'h0, 5'd0, 4'b0000);
    endtask

    task automatic ack_set(input logic a, input logic [63:0] d);
        dmem.mem_ack   = a;
        dmem.mem_rdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int req_cnt, stall_cnt;
        logic rw_seen, last, done_seen;

        tv[0]  = '{1'b1, 64'h8,  64'h0,    64'h100, 5'd3,  4'b0010, 1'b0, 64'h0,    3'b000, 64'h0,  64'h0,    5'd0,  1'b0, 64'h0,  64'h0};
        tv[1]  = '{1'b1, 64'h20, 64'h0,    64'h104, 5'd5,  4'b1010, 1'b0, 64'h0,    3'b000, 64'h8,  64'h0,    5'd3,  1'b1, 64'h8,  64'h8};
        tv[2]  = '{1'b1, 64'h77, 64'h0,    64'h64,  5'd30, 4'b0011, 1'b1, 64'h55,   3'b010, 64'h20, 64'h0,    5'd5,  1'b1, 64'h55, 64'h55};
        tv[3]  = '{1'b1, 64'h40, 64'h1234, 64'h108, 5'd9,  4'b0100, 1'b0, 64'h0,    3'b000, 64'h77, 64'h0,    5'd30, 1'b1, 64'h77, 64'h64};
        tv[4]  = '{1'b1, 64'hAB, 64'h0,    64'h10C, 5'd4,  4'b0010, 1'b0, 64'h0,    3'b111, 64'h40, 64'h1234, 5'd30, 1'b0, 64'h77, 64'h64};
        tv[5]  = tv[4];
        tv[6]  = tv[4];
        tv[7]  = '{1'b1, 64'hAB, 64'h0,    64'h10C, 5'd4,  4'b0010, 1'b1, 64'h99,   3'b011, 64'h40, 64'h1234, 5'd9,  1'b0, 64'h40, 64'h40};
        tv[8]  = '{1'b0, 64'h0,  64'h0,    64'h0,   5'd0,  4'b0000, 1'b0, 64'h0,    3'b000, 64'hAB, 64'h0,    5'd4,  1'b1, 64'hAB, 64'hAB};
        tv[9]  = '{1'b0, 64'h0,  64'h0,    64'h0,   5'd0,  4'b0000, 1'b0, 64'h0,    3'b000, 64'h0,  64'h0,    5'd4,  1'b0, 64'hAB, 64'hAB};
        tv[10] = '{1'b1, 64'h50, 64'hBEEF, 64'h200, 5'd11, 4'b1110, 1'b0, 64'h0,    3'b000, 64'h0,  64'h0,    5'd4,  1'b0, 64'hAB, 64'hAB};
        tv[11] = '{1'b0, 64'h0,  64'h0,    64'h0,   5'd0,  4'b0000, 1'b1, 64'hDEAD, 3'b011, 64'h50, 64'hBEEF, 5'd11, 1'b1, 64'h50, 64'h50};
        tv[12] = '{1'b0, 64'h0,  64'h0,    64'h0,   5'd0,  4'b0000, 1'b1, 64'h77,   3'b000, 64'h0,  64'h0,    5'd11, 1'b0, 64'h50, 64'h50};

        // asynchronous reset asserted between clock edges
        reset_n = 1'b1;
        bubble();
        ack_set(1'b0, 64'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_stall",   64'(stall),            64'h0);
        chk("rst_req",     64'(dmem.mem_req),     64'h0);
        chk("rst_we",      64'(dmem.mem_we),      64'h0);
        chk("rst_addr",    dmem.mem_addr,         64'h0);
        chk("rst_wdata",   dmem.mem_wdata,        64'h0);
        chk("rst_aw",      64'(Aw_WB),            64'h0);
        chk("rst_rw",      64'(RegWrite_WB),      64'h0);
        chk("rst_ms",      MemStage_WB,           64'h0);
        chk("rst_pc4",     PCPlusFour_WB,         64'h0);
        chk("rst_x30",     64'(Rd_X30_WB),        64'h0);
        chk("rst_fwd",     WB_fwd,                64'h0);
        chk("rst_err",     64'(mem_err),          64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // per-cycle vectors: ADDI, zero-wait LDUR, BL, STUR with 3 waits, store+load flags, stray ack
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tv[i].v, tv[i].alu, tv[i].sd, tv[i].pc4, tv[i].aw, tv[i].ctl);
            ack_set(tv[i].ack, tv[i].rdata);
            #1;
            chk($sformatf("r%0d_stall", i), 64'(stall),        64'(tv[i].e_srw[2]));
            chk($sformatf("r%0d_req", i),   64'(dmem.mem_req), 64'(tv[i].e_srw[1]));
            chk($sformatf("r%0d_we", i),    64'(dmem.mem_we),  64'(tv[i].e_srw[0]));
            chk($sformatf("r%0d_addr", i),  dmem.mem_addr,     tv[i].e_addr);
            chk($sformatf("r%0d_wdata", i), dmem.mem_wdata,    tv[i].e_wdata);
            @(posedge clk);
            #1;
            chk($sformatf("r%0d_aw_wb", i), 64'(Aw_WB),        64'(tv[i].e_aw));
            chk($sformatf("r%0d_rw_wb", i), 64'(RegWrite_WB),  64'(tv[i].e_rw));
            chk($sformatf("r%0d_ms_wb", i), MemStage_WB,       tv[i].e_ms);
            chk($sformatf("r%0d_fwd", i),   WB_fwd,            tv[i].e_fwd);
            chk($sformatf("r%0d_err", i),   64'(mem_err),      64'h0);
        end

        // load that is never acknowledged
        @(negedge clk);
        drive(1'b1, 64'h80, 64'h0, 64'h300, 5'd6, 4'b1010);
        ack_set(1'b0, 64'h0);
        @(posedge clk);
        req_cnt   = 0;
        stall_cnt = 0;
        rw_seen   = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            @(negedge clk);
            bubble();
            ack_set(1'b0, 64'hFFFF);
            #1;
            if (dmem.mem_req) req_cnt++;
            if (stall) stall_cnt++;
            last = dmem.mem_req & ~stall;
            @(posedge clk);
            #1;
            if (RegWrite_WB) rw_seen = 1'b1;
            if (last) done_seen = 1'b1;
        end
        chk("to_finished",  64'(done_seen),   64'h1);
        chk("to_req_cycles", 64'(req_cnt),    64'(MAX_WAIT));
        chk("to_stall_cycles", 64'(stall_cnt), 64'(MAX_WAIT - 1));
        chk("to_no_write",  64'(rw_seen),     64'h0);
        chk("to_aw_wb",     64'(Aw_WB),       64'h6);
        chk("to_ms_wb",     MemStage_WB,      64'h0);
        chk("to_err",       64'(mem_err),     64'h1);

        // pipeline resumes after the timeout
        @(negedge clk);
        drive(1'b1, 64'h11, 64'h0, 64'h304, 5'd2, 4'b0010);
        @(posedge clk);
        @(negedge clk);
        bubble();
        #1;
        chk("res_req",   64'(dmem.mem_req), 64'h0);
        chk("res_stall", 64'(stall),        64'h0);
        @(posedge clk);
        #1;
        chk("res_rw_wb", 64'(RegWrite_WB),  64'h1);
        chk("res_aw_wb", 64'(Aw_WB),        64'h2);
        chk("res_ms_wb", MemStage_WB,       64'h11);
        chk("res_err_sticky", 64'(mem_err), 64'h1);

        // back-to-back loads, reset lands during the second one's wait
        @(negedge clk);
        drive(1'b1, 64'h300, 64'h0, 64'h400, 5'd12, 4'b1010);
        ack_set(1'b0, 64'h0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 64'h308, 64'h0, 64'h404, 5'd13, 4'b1010);
        ack_set(1'b1, 64'hA1);
        #1;
        chk("b2b1_req",   64'(dmem.mem_req), 64'h1);
        chk("b2b1_addr",  dmem.mem_addr,     64'h300);
        chk("b2b1_stall", 64'(stall),        64'h0);
        @(posedge clk);
        #1;
        chk("b2b1_rw_wb", 64'(RegWrite_WB),  64'h1);
        chk("b2b1_aw_wb", 64'(Aw_WB),        64'd12);
        chk("b2b1_ms_wb", MemStage_WB,       64'hA1);
        @(negedge clk);
        bubble();
        ack_set(1'b0, 64'h0);
        #1;
        chk("b2b2_req",   64'(dmem.mem_req), 64'h1);
        chk("b2b2_addr",  dmem.mem_addr,     64'h308);
        chk("b2b2_stall", 64'(stall),        64'h1);
        @(posedge clk);
        #1;
        chk("b2b_single_write", 64'(RegWrite_WB), 64'h0);
        @(negedge clk);
        #1;
        chk("b2b2_wait_stall", 64'(stall),   64'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("b2b_rst_req",   64'(dmem.mem_req), 64'h0);
        chk("b2b_rst_stall", 64'(stall),        64'h0);
        chk("b2b_rst_addr",  dmem.mem_addr,     64'h0);
        chk("b2b_rst_rw",    64'(RegWrite_WB),  64'h0);
        chk("b2b_rst_aw",    64'(Aw_WB),        64'h0);
        chk("b2b_rst_fwd",   WB_fwd,            64'h0);
        chk("b2b_rst_err",   64'(mem_err),      64'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post_rst%0d_req", i), 64'(dmem.mem_req), 64'h0);
            @(posedge clk);
            #1;
            chk($sformatf("post_rst%0d_rw", i),  64'(RegWrite_WB),  64'h0);
        end

        // FSM back in IDLE: a fresh zero-wait load completes without stalling
        @(negedge clk);
        drive(1'b1, 64'h400, 64'h0, 64'h500, 5'd14, 4'b1010);
        @(posedge clk);
        @(negedge clk);
        bubble();
        ack_set(1'b1, 64'h5A);
        #1;
        chk("idle_req",   64'(dmem.mem_req), 64'h1);
        chk("idle_stall", 64'(stall),        64'h0);
        @(posedge clk);
        #1;
        chk("idle_rw_wb", 64'(RegWrite_WB),  64'h1);
        chk("idle_aw_wb", 64'(Aw_WB),        64'd14);
        chk("idle_ms_wb", MemStage_WB,       64'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
